// File: rtl/proc_dmem.sv
// Data memory responder: combinational 64-bit reads, byte-masked writes, clear sweep after reset.
// Optional bounds checking with write suppression and sticky error: define DMEM_BOUNDS_CHECK_EN.
module proc_dmem #(
    parameter int unsigned DATA_DEP = 512,
    parameter int unsigned IDX_WID  = $clog2(DATA_DEP)
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] addr_i,
    input  logic        wr_en_i,
    input  logic [63:0] wdata_i,
    input  logic [7:0]  wmask_i,
    output logic [63:0] rdata_o,
    output logic        ready_o,
    output logic        err_o,
    output logic [31:0] err_addr_o
);

    typedef enum logic {StInit, StRun} state_e;

    localparam logic [IDX_WID-1:0] LastIdx = IDX_WID'(DATA_DEP - 1);

    state_e             state_q, state_d;
    logic [IDX_WID-1:0] clr_idx_q, clr_idx_d;
    logic               err_q, err_d;
    logic [31:0]        err_addr_q, err_addr_d;
    logic [63:0]        mem_q [DATA_DEP];

    logic [IDX_WID-1:0] idx;
    logic               in_range;
    logic               fault;
    logic               wr_commit;

    assign idx = addr_i[IDX_WID+2:3];

`ifdef DMEM_BOUNDS_CHECK_EN
    assign in_range = (addr_i[31:IDX_WID+3] == '0);
    assign fault    = wr_en_i && (!in_range || (addr_i[2:0] != 3'b000));
`else
    // Upper and low address bits are discarded, so addresses alias modulo the array size.
    logic unused_addr;
    assign unused_addr = ^{addr_i[31:IDX_WID+3], addr_i[2:0]};
    assign in_range    = 1'b1;
    assign fault       = 1'b0;
`endif

    assign wr_commit = (state_q == StRun) && wr_en_i && !fault;

    always_comb begin
        state_d    = state_q;
        clr_idx_d  = clr_idx_q;
        err_d      = err_q;
        err_addr_d = err_addr_q;
        unique case (state_q)
            StInit: begin
                if (clr_idx_q == LastIdx) begin
                    state_d = StRun;
                end else begin
                    clr_idx_d = clr_idx_q + IDX_WID'(1);
                end
            end
            StRun: begin
                if (fault && !err_q) begin
                    err_d      = 1'b1;
                    err_addr_d = addr_i;
                end
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= StInit;
            clr_idx_q  <= '0;
            err_q      <= 1'b0;
            err_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            clr_idx_q  <= clr_idx_d;
            err_q      <= err_d;
            err_addr_q <= err_addr_d;
        end
    end

    // Array has no reset; the sweep after every reset zeroes it one word per cycle.
    always_ff @(posedge clk_i) begin
        if (state_q == StInit) begin
            mem_q[clr_idx_q] <= '0;
        end else if (wr_commit) begin
            for (int b = 0; b < 8; b++) begin
                if (wmask_i[b]) begin
                    mem_q[idx][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end
        end
    end

    assign rdata_o    = ((state_q == StRun) && in_range) ? mem_q[idx] : '0;
    assign ready_o    = (state_q == StRun);
    assign err_o      = err_q;
    assign err_addr_o = err_addr_q;

endmodule

// File: tb/tb_proc_dmem.sv
// Randomized self-checking bench for proc_dmem against a word-array reference model.
module tb_proc_dmem;

    localparam int unsigned DEP = 512;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic [31:0] addr_i = '0;
    logic        wr_en_i = 1'b0;
    logic [63:0] wdata_i = '0;
    logic [7:0]  wmask_i = '0;
    logic [63:0] rdata_o;
    logic        ready_o;
    logic        err_o;
    logic [31:0] err_addr_o;

    proc_dmem #(.DATA_DEP(DEP)) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .addr_i     (addr_i),
        .wr_en_i    (wr_en_i),
        .wdata_i    (wdata_i),
        .wmask_i    (wmask_i),
        .rdata_o    (rdata_o),
        .ready_o    (ready_o),
        .err_o      (err_o),
        .err_addr_o (err_addr_o)
    );

    always #5 clk_i = ~clk_i;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    logic [63:0] m_mem [DEP];
    bit          m_ready = 1'b0;
    bit          m_err = 1'b0;
    logic [31:0] m_err_addr = '0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, got, exp);
    endtask

    function automatic bit model_fault(input logic [31:0] a);
`ifdef DMEM_BOUNDS_CHECK_EN
        return (a >= DEP * 8) || (a % 8 != 0);
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [63:0] model_read(input logic [31:0] a);
        if (!m_ready) return '0;
`ifdef DMEM_BOUNDS_CHECK_EN
        if (a >= DEP * 8) return '0;
`endif
        return m_mem[(a / 8) % DEP];
    endfunction

    task automatic model_write(input logic [31:0] a, input logic [63:0] d, input logic [7:0] m);
        int unsigned w;
        if (!m_ready) return;
        if (model_fault(a)) begin
            if (!m_err) begin
                m_err      = 1'b1;
                m_err_addr = a;
            end
            return;
        end
        w = (a / 8) % DEP;
        for (int b = 0; b < 8; b++)
            if (m[b]) m_mem[w][8*b +: 8] = d[8*b +: 8];
    endtask

    task automatic model_clear();
        for (int i = 0; i < DEP; i++) m_mem[i] = '0;
        m_ready    = 1'b1;
        m_err      = 1'b0;
        m_err_addr = '0;
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // One cycle: check read before the edge, apply the edge, check read and error state after.
    task automatic do_op(input logic [31:0] a, input logic we, input logic [63:0] d,
                         input logic [7:0] m);
        addr_i  = a;
        wr_en_i = we;
        wdata_i = d;
        wmask_i = m;
        #1;
        check_eq("rd_pre", rdata_o, model_read(a));
        tick();
        if (we) model_write(a, d, m);
        wr_en_i = 1'b0;
        check_eq("rd_post", rdata_o, model_read(a));
        check_eq("err", {63'd0, err_o}, {63'd0, m_err});
        check_eq("err_addr", {32'd0, err_addr_o}, {32'd0, m_err_addr});
    endtask

    task automatic do_reset();
        m_ready = 1'b0;
        rst_i   = 1'b1;
        #1;
        check_eq("rst_ready", {63'd0, ready_o}, 64'd0);
        check_eq("rst_err", {63'd0, err_o}, 64'd0);
        check_eq("rst_err_addr", {32'd0, err_addr_o}, 64'd0);
        check_eq("rst_rdata", rdata_o, 64'd0);
        tick();
        rst_i = 1'b0;
        for (int e = 1; e <= DEP; e++) begin
            tick();
            check_eq("ready_sweep", {63'd0, ready_o}, {63'd0, e == DEP});
        end
        model_clear();
    endtask

    logic [7:0] masks [5];
    int unsigned edges;

    initial begin
        masks[0] = 8'hFF; masks[1] = 8'h0F; masks[2] = 8'h03; masks[3] = 8'h00; masks[4] = 8'h5A;

        // Reset and sweep, then every word reads zero.
        do_reset();
        for (int i = 0; i < DEP; i++) begin
            addr_i = 32'(i * 8);
            #1;
            check_eq("clear_rd", rdata_o, 64'd0);
        end

        // Reset clears previously written contents.
        do_op(32'h10, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
        do_reset();
        do_op(32'h10, 1'b0, '0, 8'h00);
        check_eq("preset_cleared", rdata_o, 64'd0);

        // Masked writes at 0x40.
        do_op(32'h40, 1'b1, 64'h1122334455667788, 8'hFF);
        do_op(32'h40, 1'b1, 64'hAAAAAAAABBBBBBBB, 8'h0F);
        do_op(32'h40, 1'b1, 64'hCCCCCCCCCCCC9999, 8'h03);
        check_eq("masked_seq", rdata_o, 64'h11223344BBBB9999);

        // Same-cycle read/write at 0x80.
        do_op(32'h80, 1'b1, 64'd5, 8'hFF);
        addr_i  = 32'h80;
        wr_en_i = 1'b1;
        wdata_i = 64'd7;
        wmask_i = 8'hFF;
        #1;
        check_eq("rw_before", rdata_o, 64'd5);
        tick();
        check_eq("rw_after", rdata_o, 64'd7);
        wdata_i = 64'h123;
        wmask_i = 8'h00;
        tick();
        check_eq("rw_mask0", rdata_o, 64'd7);
        wr_en_i = 1'b0;
        model_write(32'h80, 64'd7, 8'hFF);

        // Write during the sweep is dropped; bounded wait for ready.
        m_ready = 1'b0;
        rst_i   = 1'b1;
        #1;
        tick();
        rst_i = 1'b0;
        repeat (3) tick();
        addr_i  = 32'h0;
        wdata_i = 64'hDEAD;
        wmask_i = 8'hFF;
        wr_en_i = 1'b1;
        tick();
        wr_en_i = 1'b0;
        edges   = 4;
        while (!ready_o && edges < 600) begin
            tick();
            edges++;
        end
        check_eq("init_ready_edges", 64'(edges), 64'(DEP));
        model_clear();
        do_op(32'h0, 1'b0, '0, 8'h00);
        check_eq("init_wr_dropped", rdata_o, 64'd0);

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            logic [31:0] a;
            a = 32'($urandom_range(0, DEP - 1)) << 3;
`ifndef DMEM_BOUNDS_CHECK_EN
            if ($urandom_range(0, 3) == 0) a = a | ($urandom & 32'hFFFF_F000) | ($urandom & 32'h7);
`endif
            do_op(a, 1'($urandom_range(0, 2) != 0), {$urandom, $urandom},
                  masks[$urandom_range(0, 4)]);
        end

        // Out-of-range writes: suppressed with sticky error, or aliased without bounds checking.
        do_op(32'h8, 1'b1, 64'h0808, 8'hFF);
        do_op(32'h1000, 1'b1, 64'hCAFE, 8'hFF);
        do_op(32'h2008, 1'b1, 64'hBEEF, 8'hFF);
`ifdef DMEM_BOUNDS_CHECK_EN
        check_eq("bc_err", {63'd0, err_o}, 64'd1);
        check_eq("bc_err_addr", {32'd0, err_addr_o}, 64'h1000);
        do_op(32'h8, 1'b0, '0, 8'h00);
        check_eq("bc_word8", rdata_o, 64'h0808);
`else
        check_eq("alias_err", {63'd0, err_o}, 64'd0);
        do_op(32'h0, 1'b0, '0, 8'h00);
        check_eq("alias_word0", rdata_o, 64'hCAFE);
        do_op(32'h8, 1'b0, '0, 8'h00);
        check_eq("alias_word8", rdata_o, 64'hBEEF);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/proc_dmem.md
# proc_dmem

Data memory responder for the single-cycle RV64 processor's data port. It answers the processor's `addr`/`wr_en`/`wdata`/`wmask` requests with a combinational 64-bit `rdata` and commits byte-masked writes on the clock edge. After every reset it runs a clear sweep that zeroes the whole array one word per cycle and raises `ready` when the sweep is done. It sits between the processor's data-side outputs and its `rdata` input, alongside the instruction memory.

## Interface
- `DATA_DEP`, 512: depth in 64-bit words; must be a power of two, at least 2.
- `IDX_WID`, $clog2(DATA_DEP): word index width, 9 at the default depth.
- `clk` in 1: single clock; all state changes on the rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `addr` in 32: byte address from the processor; word index = `addr[IDX_WID+2:3]`.
- `wr_en` in 1: write request for the current cycle.
- `wdata` in 64: write data; byte i is `wdata[8i+7:8i]`.
- `wmask` in 8: byte enables; bit i enables byte i. The processor issues 0xFF for sd, 0x0F for sw, 0x03 for sh.
- `rdata` out 64: combinational read data for `addr`.
- `ready` out 1: high once the clear sweep has finished.
- `err` out 1: sticky error flag; tied to 0 unless the bounds-check feature is compiled in (see Configuration).
- `err_addr` out 32: address of the first faulting write; tied to 0 unless the bounds-check feature is compiled in.

## Operation
- The state machine has two states, INIT and RUN.
- On `rst`:
  - State goes to INIT; clear counter `clr_idx` goes to 0.
  - `ready` = 0, `err` = 0, `err_addr` = 0.
  - `rdata` = 0 while in INIT.
- INIT, on each rising edge:
  - `mem[clr_idx]` <= 0, then `clr_idx` increments.
  - When `clr_idx` == DATA_DEP-1, the next state is RUN.
  - All processor writes are ignored; `rdata` = 0.
- RUN:
  - `rdata` = `mem[index]`.
  - On a rising edge with `wr_en`=1, every byte whose `wmask` bit is set takes the matching `wdata` byte. Bytes whose mask bit is clear keep their value.
  - `wr_en`=1 with `wmask`=0 changes nothing.
- Alignment:
  - `addr[2:0]` is ignored for indexing; the processor drives these bits as 0.
  - The mask is always applied relative to byte 0 of the addressed word.
- Read with a write to the same word in the same cycle: `rdata` shows the old contents until the edge, and the new contents from the edge onward.
- Reset mid-sweep or during RUN: the sweep restarts at index 0 and the entire array is cleared again.
- Width rules:
  - `clr_idx` is IDX_WID bits wide and does not wrap past DATA_DEP-1, because the state leaves INIT at that value.
  - Address bits above `IDX_WID+2` are treated as described in Configuration.

## Timing
- Read latency is 0 cycles; `rdata` is purely combinational from `addr` and the array.
- Write latency is 1 edge; the new data is visible on `rdata` immediately after the edge.
- `ready` rises right after the DATA_DEP-th rising edge following `rst` deassertion: 512 edges at the default depth.
- `ready` stays high until the next `rst`.
- There is no handshake; the processor must hold writes off (or accept that they are dropped) until `ready`=1.
- `err` and `err_addr` update on the edge where the faulting write is presented.

## Configuration
- Macro: `DMEM_BOUNDS_CHECK_EN`.
- Defined:
  - A write is faulting if `addr[31:IDX_WID+3]` != 0 or `addr[2:0]` != 0.
  - A faulting write is suppressed.
  - If the address is out of range, `rdata` = 0.
  - On the first faulting write, `err` sets and stays set until `rst`, and `err_addr` captures that `addr`. Later faults do not change `err_addr`.
- Undefined:
  - Upper address bits are discarded, so addresses alias modulo DATA_DEP*8.
  - Low address bits are ignored.
  - `err` and `err_addr` are constant 0.

## Test plan
- Pulse `rst` then release: `ready`=0 for 511 edges and 1 after the 512th edge; `rdata`=0 at every `addr` 0x000–0xFF8.
- Reset sweep with preset contents: in RUN, write 0xFFFF_FFFF_FFFF_FFFF to 0x10, pulse `rst`, wait for `ready`; `rdata` at 0x10 reads 0.
- Masked writes at 0x40: write 0x1122334455667788 with mask 0xFF, then 0xAAAAAAAABBBBBBBB with mask 0x0F, then 0xCCCCCCCCCCCC9999 with mask 0x03; `rdata` reads 0x11223344BBBB9999.
- Same-cycle read/write: hold `addr`=0x80 (contents 5) while writing 7 with mask 0xFF; `rdata`=5 before the edge and 7 after it; a write with mask 0x00 leaves 7.
- Write during INIT: 3 edges after `rst` release, write 0xDEAD to 0x0; after `ready`, `rdata` at 0x0 = 0.
- Bounds check, with `DMEM_BOUNDS_CHECK_EN` defined:
  - Write to 0x1000: suppressed, `err`=1, `err_addr`=0x1000; a later write to 0x8 (address 0x2008 wrapping into it) leaves 0x8 unchanged and `err_addr` unchanged.
  - With the macro undefined, the same write to 0x1000 lands in word 0 and `err` stays 0.
